row_window: RTL and testbench
=============================

# row_window

Vertical window generator for the stream-filter datapath. It accepts a raster pixel stream and, for every input pixel, emits a column of HEIGHT_NB vertically aligned pixels: the current pixel and the pixels at the same column in each of the previous HEIGHT_NB-1 rows. It keeps those rows in on-chip row-delay memories sized by the runtime row length `cfg_delay`. It sits upstream of the filter arithmetic and the `clip` stage and shares their configuration word.

## Interface

- `HEIGHT_NB`, default 3: window height (rows per output column), ≥2.
- `IMG_WIDTH`, default 8: pixel width in bits.
- `MEM_AWIDTH`, default 12: row-memory address width; also the width of `cfg_delay`.
- `MEM_DEPTH`, default `1<<MEM_AWIDTH`: row-memory depth in words.

Ports:

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_delay`  in  MEM_AWIDTH: row length in pixels.
- `cfg_set`  in  1: one-cycle strobe that loads `cfg_delay` and restarts the window.
- `up_data`  in  IMG_WIDTH: input pixel.
- `up_val`  in  1: input pixel valid.
- `dn_data`  out  HEIGHT_NB*IMG_WIDTH: output column. Slice k (bits `[k*IMG_WIDTH +: IMG_WIDTH]`) is the pixel from k rows earlier. Slice 0 is the current pixel.
- `dn_val`  out  1: output column valid.

## Operation

**Configuration**
- On `cfg_set`, register `row_len = max(cfg_delay, 2)`. Values 0 and 1 are clamped to 2.
- In the same cycle, clear `col_addr` and `rows_seen`.
- An `up_val` asserted in the `cfg_set` cycle is discarded: no write, no `dn_val`.

**Column address**
- `col_addr` (MEM_AWIDTH bits) advances by 1 on each accepted `up_val`.
- It wraps to 0 when `col_addr == row_len-1`.

**Priming count**
- `rows_seen` counts 0..HEIGHT_NB-1. It increments on each wrap and saturates at HEIGHT_NB-1.

**Row memories**
- HEIGHT_NB-1 simple dual-port memories `mem[0..HEIGHT_NB-2]`, MEM_DEPTH × IMG_WIDTH.
- Stage 1 (cycle of `up_val`): read all memories at `col_addr`. Register `up_data`, `col_addr` and the valid as `s1_*`.
- Stage 2 (next cycle, if `s1_val`):
  - Read data `rd[k]` is available.
  - Write `mem[0][s1_addr] <= s1_data` and `mem[k][s1_addr] <= rd[k-1]` for k ≥ 1.
  - Register the column `{rd[HEIGHT_NB-2], …, rd[0], s1_data}` into `dn_data`.
- Because `row_len ≥ 2`, stage-2 write and stage-1 read never target the same address in the same cycle. No bypass is needed.

**Valid generation**
- `dn_val` = `s1_val` delayed one cycle AND `primed`.
- `primed` is `(rows_seen == HEIGHT_NB-1)` captured at stage 1.
- The first HEIGHT_NB-1 rows after `cfg_set` or reset prime the memories and produce no output.

**Data path**
- Pure delay; no arithmetic on pixels.
- Memory contents are not cleared by `rst` or `cfg_set`. Priming guarantees stale contents are never presented with `dn_val=1`.

## Timing

- **Latency**: `up_val` at cycle t gives `dn_val` at t+2, with slice 0 equal to `up_data` from cycle t.
- **Throughput**: one pixel per cycle. Arbitrary gaps in `up_val` are allowed. The pipeline advances every cycle, and the valid travels with the data.
- **Reset values**: `dn_val=0`, `dn_data=0`, `col_addr=0`, `rows_seen=0`, `s1_val=0`.
- **`row_len`**: undefined until the first `cfg_set`. The bench always issues `cfg_set` after reset.
- **Reset mid-row**: in-flight stage-1/stage-2 pixels are dropped, and `dn_val` is 0 from the cycle after `rst`.
  - `rst` does not reload the config.
  - Streaming may resume without `cfg_set`, and priming restarts.
- **`cfg_set` mid-stream**: pixels already in stage 1/2 still complete their write and output. Priming restarts from the next accepted pixel.
- **`rst` and `cfg_set` together**: `rst` clears state, and the config still loads.

## Test plan

- **Basic window**: HEIGHT_NB=3, `cfg_delay`=4, stream ramp 0..19 back-to-back.
  - First `dn_val` occurs 2 cycles after pixel 8, with `dn_data`={0,4,8} (slice2, slice1, slice0).
  - Exactly 12 valid outputs, the last being {11,15,19}.
- **Gapped input**: same config, `up_val` toggling 1-0-0-1 pseudo-randomly.
  - Outputs are identical in value and order to the basic window test; each `dn_val` is exactly 2 cycles after its input.
- **Clamp**: `cfg_delay`=1, HEIGHT_NB=3, ramp 0..9.
  - Behaves as `row_len`=2: first output after pixel 4 is {0,2,4}; no read/write collision corruption.
- **Reconfigure**: run `cfg_delay`=4 for 10 pixels, then `cfg_set` with `cfg_delay`=6 and `up_val`=1 in the same cycle.
  - The `cfg_set`-cycle pixel is dropped.
  - No `dn_val` for the next 12 pixels; the 13th yields {p0, p6, p12} of the new sequence.
- **Reset mid-stream**: assert `rst` for one cycle after pixel 9 of the basic window test.
  - `dn_val`=0 from the next cycle.
  - Priming restarts, with the first new output after the 9th post-reset pixel.
- **Wrap at maximum**: `cfg_delay`=4095 (MEM_AWIDTH=12), three full rows.
  - `col_addr` wraps at 4094.
  - Row 2 column 0 output = {row0[0], row1[0], row2[0]}.

Source files
------------

// File: rtl/row_window.sv
// row_window: vertical window generator for the stream-filter datapath.
// For every accepted raster pixel it emits a column of HEIGHT_NB pixels:
// the current pixel plus the pixels at the same column in the previous
// HEIGHT_NB-1 rows. Those rows are held in HEIGHT_NB-1 row-delay memories
// whose active length is the runtime row length.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_delay  row length in pixels (0 and 1 are clamped to 2)
//   cfg_set    one-cycle strobe: load cfg_delay, restart the window
//   up_data    input pixel
//   up_val     input pixel valid
//   dn_data    output column; slice k is the pixel from k rows earlier
//   dn_val     output column valid (two cycles after the input pixel)
module row_window #(
  parameter int unsigned HEIGHT_NB  = 3,
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned MEM_AWIDTH = 12,
  parameter int unsigned MEM_DEPTH  = 1 << MEM_AWIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MEM_AWIDTH-1:0]          cfg_delay,
  input  logic                           cfg_set,
  input  logic [IMG_WIDTH-1:0]           up_data,
  input  logic                           up_val,
  output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_data,
  output logic                           dn_val
);

  localparam int unsigned NumMem = HEIGHT_NB - 1;
  localparam int unsigned RsW    = (HEIGHT_NB > 2) ? $clog2(HEIGHT_NB) : 1;
  localparam logic [RsW-1:0]        RsMax  = RsW'(HEIGHT_NB - 1);
  localparam logic [MEM_AWIDTH-1:0] MinLen = MEM_AWIDTH'(2);

  logic [MEM_AWIDTH-1:0] row_len_q;
  logic [MEM_AWIDTH-1:0] col_addr_q, col_addr_d;
  logic [RsW-1:0]        rows_seen_q, rows_seen_d;
  logic                  accept;
  logic                  at_wrap;

  logic                  s1_val_q;
  logic                  s1_primed_q;
  logic [IMG_WIDTH-1:0]  s1_data_q;
  logic [MEM_AWIDTH-1:0] s1_addr_q;

  // Read data of every row memory, memory k in slice k.
  logic [NumMem*IMG_WIDTH-1:0] rd_flat;

  logic                           dn_val_q;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_data_q;

  // A pixel arriving together with cfg_set belongs to neither configuration.
  assign accept  = up_val & ~cfg_set;
  assign at_wrap = (col_addr_q == row_len_q - MEM_AWIDTH'(1));

  always_comb begin
    col_addr_d  = col_addr_q;
    rows_seen_d = rows_seen_q;
    if (accept) begin
      if (at_wrap) begin
        col_addr_d = '0;
        if (rows_seen_q != RsMax) rows_seen_d = rows_seen_q + RsW'(1);
      end else begin
        col_addr_d = col_addr_q + MEM_AWIDTH'(1);
      end
    end
  end

  // Config is deliberately not reset: rst keeps the last loaded row length.
  always_ff @(posedge clk) begin
    if (cfg_set) row_len_q <= (cfg_delay < MinLen) ? MinLen : cfg_delay;
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_set) begin
      col_addr_q  <= '0;
      rows_seen_q <= '0;
    end else begin
      col_addr_q  <= col_addr_d;
      rows_seen_q <= rows_seen_d;
    end
  end

  // Stage 1: capture the pixel, its column and whether the window is primed.
  always_ff @(posedge clk) begin
    if (rst) s1_val_q <= 1'b0;
    else     s1_val_q <= accept;
  end

  always_ff @(posedge clk) begin
    s1_data_q   <= up_data;
    s1_addr_q   <= col_addr_q;
    s1_primed_q <= (rows_seen_q == RsMax);
  end

  // Row memories form a cascade: memory 0 stores the incoming pixel, memory k
  // stores what memory k-1 held at that column, i.e. the pixel k+1 rows back.
  // Row length >= 2 keeps the stage-2 write address off the stage-1 read
  // address, so no bypass is needed.
  for (genvar k = 0; k < NumMem; k++) begin : g_mem
    logic [IMG_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [IMG_WIDTH-1:0] rd_q;
    logic [IMG_WIDTH-1:0] wr_data;

    if (k == 0) begin : g_first
      assign wr_data = s1_data_q;
    end else begin : g_next
      assign wr_data = rd_flat[(k-1)*IMG_WIDTH +: IMG_WIDTH];
    end

    always_ff @(posedge clk) begin
      rd_q <= mem_q[col_addr_q];
      if (s1_val_q && !rst) mem_q[s1_addr_q] <= wr_data;
    end

    assign rd_flat[k*IMG_WIDTH +: IMG_WIDTH] = rd_q;
  end

  // Stage 2: register the assembled column.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_val_q  <= 1'b0;
      dn_data_q <= '0;
    end else begin
      dn_val_q <= s1_val_q & s1_primed_q;
      if (s1_val_q) dn_data_q <= {rd_flat, s1_data_q};
    end
  end

  assign dn_val  = dn_val_q;
  assign dn_data = dn_data_q;

endmodule

// File: tb/tb_row_window.sv
// Self-checking bench for row_window (HEIGHT_NB=3, IMG_WIDTH=8, MEM_AWIDTH=12).
// The reference model keeps the list of pixels accepted since the last
// restart; pixel n of a primed stream is expected two cycles later with
// slice k equal to pixel n - k*row_len.
module tb_row_window;

  localparam int H  = 3;
  localparam int W  = 8;
  localparam int AW = 12;
  localparam int DW = H * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_set = 1'b0;
  logic [AW-1:0] cfg_delay = '0;
  logic          up_val = 1'b0;
  logic [W-1:0]  up_data = '0;
  logic [DW-1:0] dn_data;
  logic          dn_val;

  row_window #(
    .HEIGHT_NB (H),
    .IMG_WIDTH (W),
    .MEM_AWIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_delay(cfg_delay),
    .cfg_set  (cfg_set),
    .up_data  (up_data),
    .up_val   (up_val),
    .dn_data  (dn_data),
    .dn_val   (dn_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            row_len = 2;
  int            pix[$];
  logic          m_p1_v = 1'b0;
  logic [DW-1:0] m_p1_d = '0;
  logic          m_out_v = 1'b0;
  logic [DW-1:0] m_out_d = '0;

  // Valid output columns observed since the last got.delete().
  logic [DW-1:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gq(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input logic v, input int d, input logic cs, input int cd, input logic r);
    int n;
    up_val    = v;
    up_data   = W'(d);
    cfg_set   = cs;
    cfg_delay = AW'(cd);
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_out_v = 1'b0;
      m_out_d = '0;
      m_p1_v  = 1'b0;
      pix.delete();
    end else begin
      m_out_v = m_p1_v;
      if (m_p1_v) m_out_d = m_p1_d;
      m_p1_v = 1'b0;
      if (cs) begin
        pix.delete();
      end else if (v) begin
        pix.push_back(d & 255);
        n = pix.size() - 1;
        if (n / row_len >= H - 1) begin
          m_p1_v = 1'b1;
          for (int k = 0; k < H; k++) m_p1_d[k*W +: W] = W'(pix[n - k*row_len]);
        end
      end
    end
    if (cs) row_len = (cd < 2) ? 2 : cd;
    #1;
    chk("dn_val", dn_val, m_out_v);
    if (m_out_v) chk("dn_data", dn_data, m_out_d);
    if (dn_val === 1'b1) got.push_back(dn_data);
  endtask

  task automatic px(input int d);
    cyc(1'b1, d, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic cfg(input int cd);
    cyc(1'b0, 0, 1'b1, cd, 1'b0);
  endtask

  int   r0c0, r1c0, r2c0;
  int   d;
  logic cs_r, rs_r;

  initial begin
    // Reset
    cyc(1'b0, 0, 1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b0, 0, 1'b1);
    chk("reset_val", dn_val, 1'b0);
    chk("reset_data", dn_data, 0);

    // Basic window: row length 4, ramp 0..19
    cfg(4);
    got.delete();
    for (int i = 0; i < 20; i++) px(i);
    idle(2);
    chk("basic_count", got.size(), 12);
    chk("basic_first", gq(0), 24'h000408);
    chk("basic_last", gq(11), 24'h0b0f13);

    // Gapped input, same config
    cfg(4);
    got.delete();
    for (int i = 0; i < 20;) begin
      if ($urandom_range(0, 2) == 0) begin
        px(i);
        i++;
      end else begin
        idle(1);
      end
    end
    idle(3);
    chk("gap_count", got.size(), 12);
    chk("gap_first", gq(0), 24'h000408);
    chk("gap_last", gq(11), 24'h0b0f13);

    // Clamp: cfg_delay=1 behaves as row length 2
    cfg(1);
    got.delete();
    for (int i = 0; i < 10; i++) px(i);
    idle(2);
    chk("clamp_count", got.size(), 6);
    chk("clamp_first", gq(0), 24'h000204);
    chk("clamp_last", gq(5), 24'h050709);

    // Reconfigure mid-stream with a pixel in the cfg_set cycle
    cfg(4);
    for (int i = 0; i < 10; i++) px(i);
    cyc(1'b1, 77, 1'b1, 6, 1'b0);
    got.delete();
    for (int i = 0; i < 13; i++) px(100 + i);
    idle(2);
    chk("reconf_count", got.size(), 1);
    chk("reconf_first", gq(0), 24'h646a70);

    // Reset mid-stream, config kept
    cfg(4);
    for (int i = 0; i < 10; i++) px(i);
    cyc(1'b0, 0, 1'b0, 0, 1'b1);
    chk("rst_mid_val", dn_val, 1'b0);
    got.delete();
    for (int i = 0; i < 20; i++) px(50 + i);
    idle(2);
    chk("rst_mid_count", got.size(), 12);
    chk("rst_mid_first", gq(0), 24'h32363a);

    // rst and cfg_set together: state cleared, config loaded
    cyc(1'b0, 0, 1'b1, 3, 1'b1);
    got.delete();
    for (int i = 0; i < 12; i++) px(200 + i);
    idle(2);
    chk("rst_cfg_count", got.size(), 6);
    chk("rst_cfg_first", gq(0), 24'hc8cbce);

    // Wrap at maximum row length, random pixels
    cfg(4095);
    got.delete();
    r0c0 = 0;
    r1c0 = 0;
    r2c0 = 0;
    for (int i = 0; i < 3 * 4095; i++) begin
      d = int'($urandom_range(0, 255));
      if (i == 0)        r0c0 = d;
      if (i == 4095)     r1c0 = d;
      if (i == 2 * 4095) r2c0 = d;
      px(d);
    end
    idle(2);
    chk("wrap_count", got.size(), 4095);
    chk("wrap_first", gq(0), {W'(r0c0), W'(r1c0), W'(r2c0)});

    // Random mix of gaps, reconfigurations and resets
    cfg(int'($urandom_range(0, 7)));
    for (int i = 0; i < 800; i++) begin
      cs_r = ($urandom_range(0, 49) == 0);
      rs_r = ($urandom_range(0, 79) == 0);
      cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)), cs_r,
          int'($urandom_range(0, 7)), rs_r);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
